hd_serial_decoder: RTL

- Receive side of the Hamming link; sits directly downstream of the Hamming encoder / error-injection channel.
- Assembles a bit-serial Hamming(17,12) SEC codeword, computes the 5-bit syndrome and corrects single-bit errors.
- Delivers the 12-bit data word, with status flags, to the consumer through a one-entry valid/ready output register.
- Keeps saturating counts of corrected and uncorrectable frames.

---
 rtl/hd_pkg.sv | 48 ++++
 rtl/hd_syndrome_correct.sv | 31 +++
 rtl/hd_serial_decoder.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/hd_pkg.sv
// Shared Hamming(17,12) layout: widths, data-position table, syndrome masks
// and the helpers both the encoder and the decoder use.
package hd_pkg;

    localparam int DATA_W = 12;
    localparam int PAR_W  = 5;
    localparam int CW_W   = DATA_W + PAR_W;
    localparam int CNT_W  = 16;

    // Codeword position (1-based) of each data bit, ascending non-powers-of-two.
    localparam int DATA_POS [DATA_W] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15, 17};

    // Bit p-1 of mask k is set when position p has index bit k set.
    localparam logic [CW_W-1:0] SYN_MASK [PAR_W] = '{
        17'h15555,
        17'h06666,
        17'h07878,
        17'h07F80,
        17'h18000
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_DECODE = 2'd2
    } hd_state_e;

    // Pull the data bits out of a codeword (bit p-1 holds position p).
    function automatic logic [DATA_W-1:0] hd_extract(input logic [CW_W-1:0] cw);
        logic [DATA_W-1:0] d;
        d = '0;
        for (int i = 0; i < DATA_W; i++) begin
            d[i] = cw[DATA_POS[i] - 1];
        end
        return d;
    endfunction

    // Even-parity syndrome: each bit is the XOR of the positions in its mask.
    function automatic logic [PAR_W-1:0] hd_syndrome(input logic [CW_W-1:0] cw);
        logic [PAR_W-1:0] s;
        s = '0;
        for (int k = 0; k < PAR_W; k++) begin
            s[k] = ^(cw & SYN_MASK[k]);
        end
        return s;
    endfunction

endpackage

// File: rtl/hd_syndrome_correct.sv
// Combinational syndrome computation and single-bit correction of one codeword.
module hd_syndrome_correct
    import hd_pkg::*;
(
    input  logic [CW_W-1:0]   cw,
    output logic [PAR_W-1:0]  syndrome,
    output logic [DATA_W-1:0] data,
    output logic              corr,
    output logic              uncorr
);

    logic [PAR_W-1:0] syn_s;
    logic [CW_W-1:0]  flip_s;
    logic [CW_W-1:0]  fixed_s;

    // Syndrome selects the single position to flip; 0 and 18..31 flip nothing.
    always_comb begin
        syn_s  = hd_syndrome(cw);
        flip_s = '0;
        for (int p = 0; p < CW_W; p++) begin
            flip_s[p] = (syn_s == PAR_W'(p + 1));
        end
        fixed_s = cw ^ flip_s;
    end

    assign syndrome = syn_s;
    assign data     = hd_extract(fixed_s);
    assign corr     = |flip_s;
    assign uncorr   = (syn_s > PAR_W'(CW_W));

endmodule

// File: rtl/hd_serial_decoder.sv
// Bit-serial Hamming(17,12) receiver: frame assembly, SEC decode, one-entry
// valid/ready output register and saturating error counters.
module hd_serial_decoder
    import hd_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_bit,
    input  logic              s_valid,
    input  logic              s_sof,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_corr,
    output logic              m_uncorr,
    output logic [PAR_W-1:0]  m_syndrome,
    output logic [CNT_W-1:0]  corr_count,
    output logic [CNT_W-1:0]  uncorr_count
);

    localparam logic [4:0]       LAST_CNT = 5'd16;
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    hd_state_e         state_r;
    hd_state_e         state_s;
    logic [4:0]        cnt_r;
    logic [CW_W-1:0]   shreg_r;
    logic              ready_s;
    logic              accept_s;
    logic              take_s;

    logic [DATA_W-1:0] dec_data_s;
    logic [PAR_W-1:0]  dec_syn_s;
    logic              dec_corr_s;
    logic              dec_uncorr_s;

    logic [DATA_W-1:0] m_data_r;
    logic              m_valid_r;
    logic              m_corr_r;
    logic              m_uncorr_r;
    logic [PAR_W-1:0]  m_syn_r;
    logic [CNT_W-1:0]  corr_cnt_r;
    logic [CNT_W-1:0]  uncorr_cnt_r;

    hd_syndrome_correct u_sc (
        .cw       (shreg_r),
        .syndrome (dec_syn_s),
        .data     (dec_data_s),
        .corr     (dec_corr_s),
        .uncorr   (dec_uncorr_s)
    );

    // Hold off the completing bit while an unconsumed word would be overwritten.
    always_comb begin
        ready_s = 1'b1;
        if (state_r == ST_DECODE) begin
            ready_s = 1'b0;
        end else if ((state_r == ST_SHIFT) && (cnt_r == LAST_CNT) && m_valid_r && !m_ready) begin
            ready_s = 1'b0;
        end else begin
            ready_s = 1'b1;
        end
    end

    assign accept_s = s_valid & ready_s;
    assign take_s   = m_valid_r & m_ready;

    // Next-state logic; s_sof always restarts a frame.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && s_sof) begin
                    state_s = ST_SHIFT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (accept_s && !s_sof && (cnt_r == LAST_CNT)) begin
                    state_s = ST_DECODE;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_DECODE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Shift register fills from the top so position 1 ends up in bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_r <= '0;
            cnt_r   <= 5'd0;
        end else if (accept_s && s_sof) begin
            shreg_r <= {s_bit, {(CW_W-1){1'b0}}};
            cnt_r   <= 5'd1;
        end else if (accept_s && (state_r == ST_SHIFT)) begin
            shreg_r <= {s_bit, shreg_r[CW_W-1:1]};
            cnt_r   <= cnt_r + 5'd1;
        end else if (state_r == ST_DECODE) begin
            cnt_r   <= 5'd0;
        end
    end

    // Output register: loaded by DECODE, emptied on consumption otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data_r   <= '0;
            m_valid_r  <= 1'b0;
            m_corr_r   <= 1'b0;
            m_uncorr_r <= 1'b0;
            m_syn_r    <= '0;
        end else if (state_r == ST_DECODE) begin
            m_data_r   <= dec_data_s;
            m_valid_r  <= 1'b1;
            m_corr_r   <= dec_corr_s;
            m_uncorr_r <= dec_uncorr_s;
            m_syn_r    <= dec_syn_s;
        end else if (take_s) begin
            m_valid_r  <= 1'b0;
        end
    end

    // Error counters advance when a flagged word is consumed, saturating at max.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_cnt_r   <= '0;
            uncorr_cnt_r <= '0;
        end else if (take_s) begin
            if (m_corr_r && (corr_cnt_r != CNT_MAX)) begin
                corr_cnt_r <= corr_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (m_uncorr_r && (uncorr_cnt_r != CNT_MAX)) begin
                uncorr_cnt_r <= uncorr_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign s_ready      = ready_s;
    assign m_data       = m_data_r;
    assign m_valid      = m_valid_r;
    assign m_corr       = m_corr_r;
    assign m_uncorr     = m_uncorr_r;
    assign m_syndrome   = m_syn_r;
    assign corr_count   = corr_cnt_r;
    assign uncorr_count = uncorr_cnt_r;

endmodule
